clkgate_ctrl: RTL and testbench

- Parametrised N-channel clock-gate controller; successor to the single-channel control gate.
- Each channel runs its own request/acknowledge FSM with a wake-settle delay and an idle hold-off timer, and drives its own latch-based gate instance (OPENROAD_CTRLGATE) for a glitch-free gated clock.
- Sits between block-level power/activity control and the clock tree of the FRIDA digital subsystems.

---
 rtl/clkgate_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_clkgate_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/clkgate_ctrl.sv
// clkgate_ctrl - N-channel clock-gate controller.
//
// Each channel runs an OFF/WAKE/ON/IDLE request-acknowledge FSM. WAKE waits
// WAKE_CYCLES before acknowledging. IDLE keeps the clock running for
// IDLE_CYCLES after req drops, and any act pulse restarts that hold-off. A
// registered gate_en drives the E pin of a latch-based OPENROAD_CTRLGATE cell
// per channel.
//
// Optional build macro: CLKGATE_FORCE_EN
//   When defined, it adds the force_on input. force_on drives TE of every gate
//   cell, so all gck run while it is high, and it also holds all_off low.
//   When undefined, TE is tied low.
//
// Ports:
//   CK       in   free-running source clock
//   R        in   asynchronous active-low reset
//   force_on in   (CLKGATE_FORCE_EN only) run all gated clocks
//   req      in   [NCH] per-channel clock request (level)
//   act      in   [NCH] per-channel activity pulse, re-arms the idle timer
//   ack      out  [NCH] registered clock-valid acknowledge
//   gate_en  out  [NCH] registered gate-cell enable
//   gck      out  [NCH] gated clocks
//   all_off  out  high when no channel has its gate enabled

// Behavioural model of the latch-based clock gate cell.
// The enable is captured while CK is low, so GCK never glitches.
module OPENROAD_CTRLGATE (
  input  logic CK,
  input  logic E,
  input  logic TE,
  output logic GCK
);
  logic en_l;

  always_latch begin
    if (!CK) en_l = E | TE;
  end

  assign GCK = CK & en_l;
endmodule

// Per-channel request/acknowledge FSM with a shared wake/idle down-counter.
module clkgate_chan #(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic act,
  output logic ack,
  output logic gate_en
);
  typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON, S_IDLE} state_t;

  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ge_q, ge_d, ack_q, ack_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      ge_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ge_q    <= ge_d;
      ack_q   <= ack_d;
    end
  end

  // ack and gate_en are computed alongside the next state and then
  // registered. Both outputs therefore come straight from flops and are
  // never decoded combinationally from the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ge_d    = ge_q;
    ack_d   = ack_q;
    case (state_q)
      S_OFF: begin
        if (req) begin
          state_d = S_WAKE;
          ge_d    = 1'b1;
          cnt_d   = WAKE_LD;
        end
      end
      S_WAKE: begin
        if (!req) begin
          state_d = S_OFF;
          ge_d    = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = S_ON;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ON: begin
        if (!req) begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
          cnt_d   = IDLE_LD;
        end
      end
      S_IDLE: begin
        // The clock never stopped in IDLE, so a new request returns to ON
        // at once without another wake delay.
        if (req) begin
          state_d = S_ON;
          ack_d   = 1'b1;
        end else if (act) begin
          cnt_d = IDLE_LD;
        end else if (cnt_q == '0) begin
          state_d = S_OFF;
          ge_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_OFF;
        ge_d    = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  assign ack     = ack_q;
  assign gate_en = ge_q;
endmodule

module clkgate_ctrl #(
  parameter int NCH         = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = $clog2(((WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES) + 1)
) (
  input  logic           CK,
  input  logic           R,
`ifdef CLKGATE_FORCE_EN
  input  logic           force_on,
`endif
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] act,
  output logic [NCH-1:0] ack,
  output logic [NCH-1:0] gate_en,
  output logic [NCH-1:0] gck,
  output logic           all_off
);
  logic te;

`ifdef CLKGATE_FORCE_EN
  assign te      = force_on;
  assign all_off = (&(~gate_en)) & ~force_on;
`else
  assign te      = 1'b0;
  assign all_off = &(~gate_en);
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clkgate_chan #(
      .WAKE_CYCLES (WAKE_CYCLES),
      .IDLE_CYCLES (IDLE_CYCLES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk     (CK),
      .rst_n   (R),
      .req     (req[g]),
      .act     (act[g]),
      .ack     (ack[g]),
      .gate_en (gate_en[g])
    );

    OPENROAD_CTRLGATE u_cg (
      .CK  (CK),
      .E   (gate_en[g]),
      .TE  (te),
      .GCK (gck[g])
    );
  end
endmodule

// File: tb/tb_clkgate_ctrl.sv
module tb_clkgate_ctrl;
  localparam int NCH = 4;
  localparam int W   = 2;
  localparam int I   = 8;

  logic           CK = 1'b0;
  logic           R;
  logic [NCH-1:0] req, act, ack, gate_en, gck;
  logic           all_off;
`ifdef CLKGATE_FORCE_EN
  logic           force_on;
`endif

  always #5 CK = ~CK;

  clkgate_ctrl #(.NCH(NCH), .WAKE_CYCLES(W), .IDLE_CYCLES(I)) dut (
    .CK      (CK),
    .R       (R),
`ifdef CLKGATE_FORCE_EN
    .force_on(force_on),
`endif
    .req     (req),
    .act     (act),
    .ack     (ack),
    .gate_en (gate_en),
    .gck     (gck),
    .all_off (all_off)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  typedef struct {
    logic rq;
    logic ac;
    logic e_ack;
    logic e_ge;
  } vec_t;

  vec_t tbl[14];

  // Reference model state. Timing is kept as absolute deadlines
  // (cycle numbers) rather than counters.
  bit m_en  [NCH];
  bit m_ack [NCH];
  bit m_wake[NCH];
  int m_ack_at[NCH];
  int m_off_at[NCH];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NCH-1:0] e_ack, e_ge, e_gck;
    logic           e_off;

    R = 1'b0;
    req = '0;
    act = '0;
`ifdef CLKGATE_FORCE_EN
    force_on = 1'b0;
`endif
    #12;
    chk("reset_ack", ack, 0);
    chk("reset_ge", gate_en, 0);
    chk("reset_all_off", all_off, 1);
    chk("reset_gck", gck, 0);
    R = 1'b1;
    tick();

    // Channel 1: wake, act ignored while ON, release, idle countdown.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 5; i <= 11; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      req[1] = tbl[i].rq;
      act[1] = tbl[i].ac;
      tick();
      chk($sformatf("tbl%0d_ack", i), ack[1], tbl[i].e_ack);
      chk($sformatf("tbl%0d_ge", i), gate_en[1], tbl[i].e_ge);
      chk($sformatf("tbl%0d_all_off", i), all_off, !tbl[i].e_ge);
      chk($sformatf("tbl%0d_gck", i), gck[1], (i == 0) ? 1'b0 : tbl[i-1].e_ge);
    end
    act[1] = 1'b0;

    // Channel 2: act pulses at idle cycles 3 and 9 push the gate-off point.
    req[2] = 1'b1;
    tick(); tick(); tick();
    chk("ch2_on_ack", ack[2], 1);
    req[2] = 1'b0;
    tick();
    chk("ch2_idle_ack", ack[2], 0);
    for (int i = 1; i <= 20; i++) begin
      act[2] = (i == 3 || i == 9);
      tick();
      chk($sformatf("ch2_rearm%0d_ge", i), gate_en[2], (i < 17));
    end
    act[2] = 1'b0;

    // Channel 3: a one-cycle request aborts the wake without an ack.
    req[3] = 1'b1;
    tick();
    chk("ch3_abort_ge1", gate_en[3], 1);
    chk("ch3_abort_ack1", ack[3], 0);
    req[3] = 1'b0;
    tick();
    chk("ch3_abort_ge2", gate_en[3], 0);
    chk("ch3_abort_ack2", ack[3], 0);
    tick();
    chk("ch3_abort_ack3", ack[3], 0);

    // Channel 3: a request during IDLE re-acks on the next edge.
    req[3] = 1'b1;
    tick(); tick(); tick();
    chk("ch3_on_ack", ack[3], 1);
    req[3] = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("ch3_idle%0d_ge", i), gate_en[3], 1);
      chk($sformatf("ch3_idle%0d_ack", i), ack[3], 0);
    end
    req[3] = 1'b1;
    tick();
    chk("ch3_reack_ack", ack[3], 1);
    chk("ch3_reack_ge", gate_en[3], 1);
    req[3] = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("ch3_final_ge", gate_en[3], 0);

    // Channel 0: reset asserted mid-WAKE clears the outputs at once.
    req[0] = 1'b1;
    tick();
    chk("rst_pre_ge", gate_en[0], 1);
    #2 R = 1'b0;
    #1;
    chk("rst_async_ack", ack, 0);
    chk("rst_async_ge", gate_en, 0);
    chk("rst_async_all_off", all_off, 1);
    tick();
    chk("rst_hold_ge", gate_en, 0);
    chk("rst_hold_gck", gck, 0);
    R = 1'b1;
    tick();
    chk("rst_rel_ge", gate_en[0], 1);
    chk("rst_rel_ack0", ack[0], 0);
    tick();
    chk("rst_rel_ack1", ack[0], 0);
    tick();
    chk("rst_rel_ack2", ack[0], 1);
    req[0] = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("rst_tail_all_off", all_off, 1);

    // Random traffic on all channels, compared against the deadline model.
    R = 1'b0;
    #2 R = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_ack[c] = 0; m_wake[c] = 0; m_ack_at[c] = 0; m_off_at[c] = 0;
    end
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(5, 0) == 0) req[c] = ~req[c];
        act[c] = ($urandom_range(4, 0) == 0);
        e_gck[c] = m_en[c];
      end
      tick();
      for (int c = 0; c < NCH; c++) begin
        if (!m_en[c]) begin
          if (req[c]) begin
            m_en[c] = 1; m_wake[c] = 1; m_ack_at[c] = t + W;
          end
        end else if (m_wake[c]) begin
          if (!req[c]) begin
            m_en[c] = 0; m_wake[c] = 0;
          end else if (t >= m_ack_at[c]) begin
            m_wake[c] = 0; m_ack[c] = 1;
          end
        end else if (m_ack[c]) begin
          if (!req[c]) begin
            m_ack[c] = 0; m_off_at[c] = t + I;
          end
        end else begin
          if (req[c]) m_ack[c] = 1;
          else if (act[c]) m_off_at[c] = t + I;
          else if (t >= m_off_at[c]) m_en[c] = 0;
        end
        e_ack[c] = m_ack[c];
        e_ge[c]  = m_en[c];
      end
      e_off = (e_ge == '0);
      chk($sformatf("rnd%0d_ack", t), ack, e_ack);
      chk($sformatf("rnd%0d_ge", t), gate_en, e_ge);
      chk($sformatf("rnd%0d_all_off", t), all_off, e_off);
      chk($sformatf("rnd%0d_gck", t), gck, e_gck);
    end

`ifdef CLKGATE_FORCE_EN
    req = '0;
    act = '0;
    for (int i = 0; i < 12; i++) tick();
    force_on = 1'b1;
    tick(); tick();
    chk("force_gck", gck, {NCH{1'b1}});
    chk("force_ack", ack, 0);
    chk("force_ge", gate_en, 0);
    chk("force_all_off", all_off, 0);
    force_on = 1'b0;
    tick(); tick();
    chk("unforce_gck", gck, 0);
    chk("unforce_all_off", all_off, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
